// File: rtl/tdc_histogrammer.sv
// Signed cross-correlation histogrammer for TDC events: clear, timed acquisition with a
// forwarding read-modify-write pipeline, then an in-order valid/ready dump of all 256 bins.
module tdc_histogrammer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_acq,
  input  logic [31:0]        acq_cycles,
  input  logic               evt_valid,
  input  logic [1:0]         evt_start,
  input  logic [1:0]         evt_end,
  input  logic [6:0]         evt_interval,
  output logic               busy,
  output logic               acq_done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [7:0]         rd_bin,
  output logic [COUNT_W-1:0] rd_count,
  output logic               rd_last,
  output logic [15:0]        discard_cnt
);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_ACQ, ST_DRAIN, ST_DUMP
  } state_t;

  state_t r_state;

  logic [COUNT_W-1:0] r_mem [0:255];
  logic [COUNT_W-1:0] r_ram_q;

  logic               r_evt_valid_d;
  logic [7:0]         r_clr_idx;
  logic [31:0]        r_acq_cnt;

  logic               r_s1_valid;
  logic [7:0]         r_s1_addr;
  logic               r_wr_valid;
  logic [7:0]         r_wr_addr;
  logic [COUNT_W-1:0] r_wr_data;
  logic               r_lw_valid;
  logic [7:0]         r_lw_addr;
  logic [COUNT_W-1:0] r_lw_data;

  logic [8:0]         r_dump_addr;
  logic               r_q_valid;
  logic [7:0]         r_q_bin;

  logic               r_busy;
  logic               r_acq_done;
  logic               r_rd_valid;
  logic [7:0]         r_rd_bin;
  logic [COUNT_W-1:0] r_rd_count;
  logic               r_rd_last;
  logic [15:0]        r_discard_cnt;

  logic               w_evt_rise;
  logic               w_evt_acq;
  logic               w_evt_ok;
  logic               w_evt_take;
  logic               w_evt_drop;
  logic [7:0]         w_evt_bin;
  logic [COUNT_W-1:0] w_base;
  logic [COUNT_W-1:0] w_incr;
  logic               w_hs;
  logic               w_dump_load;
  logic               w_dump_issue;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [7:0]         w_ram_waddr;
  logic [7:0]         w_ram_raddr;
  logic [COUNT_W-1:0] w_ram_wdata;

  // Only {10,01}, {01,10} and {00,11} describe a real cross-channel delay.
  always_comb begin
    w_evt_ok  = 1'b0;
    w_evt_bin = 8'd128;
    case ({evt_start, evt_end})
      4'b1001: begin
        w_evt_ok  = 1'b1;
        w_evt_bin = 8'd128 + {1'b0, evt_interval};
      end
      4'b0110: begin
        w_evt_ok  = 1'b1;
        w_evt_bin = 8'd128 - {1'b0, evt_interval};
      end
      4'b0011: begin
        w_evt_ok  = 1'b1;
        w_evt_bin = 8'd128;
      end
      default: ;
    endcase
  end

  assign w_evt_rise = evt_valid & ~r_evt_valid_d;
  assign w_evt_acq  = w_evt_rise && (r_state == ST_ACQ);
  assign w_evt_take = w_evt_acq && w_evt_ok;
  assign w_evt_drop = w_evt_acq && !w_evt_ok;

  // The RAM is read-first, so a read issued on the same edge as a write to the
  // same bin returns stale data; the two most recent writes are forwarded.
  always_comb begin
    w_base = r_ram_q;
    if (r_wr_valid && (r_wr_addr == r_s1_addr)) begin
      w_base = r_wr_data;
    end else if (r_lw_valid && (r_lw_addr == r_s1_addr)) begin
      w_base = r_lw_data;
    end
  end

  assign w_incr = (w_base == CNT_MAX) ? w_base : w_base + COUNT_W'(1);

  assign w_hs         = r_rd_valid && rd_ready;
  assign w_dump_load  = r_q_valid && (!r_rd_valid || rd_ready);
  assign w_dump_issue = (r_state == ST_DUMP) && !r_dump_addr[8] && (!r_q_valid || w_dump_load);

  assign w_ram_we    = (r_state == ST_CLEAR) || r_wr_valid;
  assign w_ram_waddr = (r_state == ST_CLEAR) ? r_clr_idx : r_wr_addr;
  assign w_ram_wdata = (r_state == ST_CLEAR) ? '0 : r_wr_data;
  assign w_ram_re    = w_evt_take || w_dump_issue;
  assign w_ram_raddr = (r_state == ST_DUMP) ? r_dump_addr[7:0] : w_evt_bin;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_waddr] <= w_ram_wdata;
    end
    if (w_ram_re) begin
      r_ram_q <= r_mem[w_ram_raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_evt_valid_d <= 1'b0;
      r_clr_idx     <= 8'd0;
      r_acq_cnt     <= 32'd0;
      r_s1_valid    <= 1'b0;
      r_s1_addr     <= 8'd0;
      r_wr_valid    <= 1'b0;
      r_wr_addr     <= 8'd0;
      r_wr_data     <= '0;
      r_lw_valid    <= 1'b0;
      r_lw_addr     <= 8'd0;
      r_lw_data     <= '0;
      r_dump_addr   <= 9'd0;
      r_q_valid     <= 1'b0;
      r_q_bin       <= 8'd0;
      r_busy        <= 1'b0;
      r_acq_done    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_bin      <= 8'd0;
      r_rd_count    <= '0;
      r_rd_last     <= 1'b0;
      r_discard_cnt <= 16'd0;
    end else begin
      r_evt_valid_d <= evt_valid;
      r_acq_done    <= 1'b0;

      r_s1_valid <= w_evt_take;
      if (w_evt_take) begin
        r_s1_addr <= w_evt_bin;
      end
      r_wr_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_wr_addr <= r_s1_addr;
        r_wr_data <= w_incr;
      end
      r_lw_valid <= r_wr_valid;
      r_lw_addr  <= r_wr_addr;
      r_lw_data  <= r_wr_data;

      if (w_evt_drop && (r_discard_cnt != 16'hFFFF)) begin
        r_discard_cnt <= r_discard_cnt + 16'd1;
      end

      // Dump prefetch: the RAM output register acts as a one-word buffer ahead of rd_*.
      if (w_dump_issue) begin
        r_dump_addr <= r_dump_addr + 9'd1;
        r_q_bin     <= r_dump_addr[7:0];
        r_q_valid   <= 1'b1;
      end else if (w_dump_load) begin
        r_q_valid <= 1'b0;
      end
      if (w_dump_load) begin
        r_rd_valid <= 1'b1;
        r_rd_bin   <= r_q_bin;
        r_rd_count <= r_ram_q;
        r_rd_last  <= (r_q_bin == 8'd255);
      end else if (w_hs) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start_acq) begin
            r_state       <= ST_CLEAR;
            r_busy        <= 1'b1;
            r_acq_cnt     <= acq_cycles;
            r_clr_idx     <= 8'd0;
            r_discard_cnt <= 16'd0;
          end
        end
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + 8'd1;
          if (r_clr_idx == 8'd255) begin
            r_state <= (r_acq_cnt == 32'd0) ? ST_DRAIN : ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (r_acq_cnt == 32'd1) begin
            r_state <= ST_DRAIN;
          end else begin
            r_acq_cnt <= r_acq_cnt - 32'd1;
          end
        end
        ST_DRAIN: begin
          if (!r_s1_valid && !r_wr_valid) begin
            r_state     <= ST_DUMP;
            r_dump_addr <= 9'd0;
            r_q_valid   <= 1'b0;
          end
        end
        ST_DUMP: begin
          if (w_hs && r_rd_last) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_acq_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign acq_done    = r_acq_done;
  assign rd_valid    = r_rd_valid;
  assign rd_bin      = r_rd_bin;
  assign rd_count    = r_rd_count;
  assign rd_last     = r_rd_last;
  assign discard_cnt = r_discard_cnt;

endmodule

// File: tb/tb_tdc_histogrammer.sv
// Scoreboard bench: each run's event list is turned into an expected 256-bin histogram by a
// plain arithmetic model; a negedge monitor pops and compares every dumped word.
`timescale 1ns/1ps
module tb_tdc_histogrammer;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_acq = 1'b0;
  logic [31:0]   acq_cycles = 32'd0;
  logic          evt_valid = 1'b0;
  logic [1:0]    evt_start = 2'd0;
  logic [1:0]    evt_end = 2'd0;
  logic [6:0]    evt_interval = 7'd0;
  logic          busy;
  logic          acq_done;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [7:0]    rd_bin;
  logic [CW-1:0] rd_count;
  logic          rd_last;
  logic [15:0]   discard_cnt;

  tdc_histogrammer #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_acq(start_acq), .acq_cycles(acq_cycles),
    .evt_valid(evt_valid), .evt_start(evt_start), .evt_end(evt_end), .evt_interval(evt_interval),
    .busy(busy), .acq_done(acq_done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_bin(rd_bin), .rd_count(rd_count), .rd_last(rd_last), .discard_cnt(discard_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] s;
    logic [1:0] e;
    logic [6:0] iv;
    int         hold;
    int         gap;
    bit         outside;
  } evt_t;

  typedef struct {
    logic [7:0] bin;
    int         cnt;
    bit         last;
  } word_t;

  evt_t  ev_q[$];
  word_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int ready_pct = 100;
  int words_seen = 0;
  int done_cnt = 0;
  bit expect_done = 1'b0;
  bit stall_chk = 1'b0;
  logic [7:0]    held_bin = 8'd0;
  logic [CW-1:0] held_cnt = '0;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic add_evt(input logic [1:0] s, input logic [1:0] e, input logic [6:0] iv,
                         input int hold, input int gap, input bit outside);
    evt_t ev;
    ev.s = s; ev.e = e; ev.iv = iv; ev.hold = hold; ev.gap = gap; ev.outside = outside;
    ev_q.push_back(ev);
  endtask

  task automatic gen_random(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      logic [3:0] se;
      logic [6:0] iv;
      r = int'($urandom_range(0, 9));
      if (r < 3)      se = 4'b1001;
      else if (r < 6) se = 4'b0110;
      else if (r < 7) se = 4'b0011;
      else            se = 4'($urandom);
      iv = ($urandom_range(0, 1) == 0) ? 7'($urandom) : 7'($urandom_range(0, 3));
      add_evt(se[3:2], se[1:0], iv, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 1'b0);
    end
  endtask

  // Reference model: delay from the channel order, bin = 128 + delay, saturating counts.
  task automatic build_expect(output int disc);
    int hist[256];
    disc = 0;
    for (int b = 0; b < 256; b++) hist[b] = 0;
    foreach (ev_q[i]) begin
      int d;
      bit ok;
      ok = 1'b1;
      d  = 0;
      if (ev_q[i].outside) continue;
      if (ev_q[i].s == 2'b10 && ev_q[i].e == 2'b01)      d = int'(ev_q[i].iv);
      else if (ev_q[i].s == 2'b01 && ev_q[i].e == 2'b10) d = -int'(ev_q[i].iv);
      else if (ev_q[i].s == 2'b00 && ev_q[i].e == 2'b11) d = 0;
      else ok = 1'b0;
      if (ok) begin
        if (hist[128 + d] < CMAX) hist[128 + d]++;
      end else begin
        disc++;
      end
    end
    for (int b = 0; b < 256; b++) begin
      word_t w;
      w.bin = 8'(b); w.cnt = hist[b]; w.last = (b == 255);
      exp_q.push_back(w);
    end
  endtask

  task automatic send_evt(input logic [1:0] s, input logic [1:0] e, input logic [6:0] iv,
                          input int hold, input int gap);
    evt_start = s; evt_end = e; evt_interval = iv; evt_valid = 1'b1;
    // Fields are scrambled after the first cycle: only the rising-edge sample may count.
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      evt_start = 2'($urandom); evt_end = 2'($urandom); evt_interval = 7'($urandom);
    end
    evt_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic do_run(input string tag, input int acq_len_in, input int rpct,
                        input bit clr_evt, input bit mid_start, input bit mid_reset);
    int disc, dur, acq_len, base_words, base_done, t;
    build_expect(disc);
    dur = 0;
    foreach (ev_q[i]) dur += ev_q[i].hold + ev_q[i].gap;
    acq_len    = (acq_len_in >= 0) ? acq_len_in : dur + 20;
    ready_pct  = rpct;
    base_words = words_seen;
    base_done  = done_cnt;
    @(posedge clk); #1;
    acq_cycles = 32'(acq_len);
    start_acq  = 1'b1;
    @(posedge clk); #1;
    start_acq  = 1'b0;
    acq_cycles = $urandom;
    check({tag, "_busy_after_start"}, busy, 1);
    if (clr_evt) begin
      send_evt(2'b10, 2'b10, 7'd3, 2, 2);
      repeat (256) begin @(posedge clk); #1; end
    end else begin
      repeat (260) begin @(posedge clk); #1; end
    end
    foreach (ev_q[i]) send_evt(ev_q[i].s, ev_q[i].e, ev_q[i].iv, ev_q[i].hold, ev_q[i].gap);
    if (mid_start) begin
      acq_cycles = 32'd1; start_acq = 1'b1;
      @(posedge clk); #1;
      start_acq = 1'b0;
    end
    t = 0;
    if (mid_reset) begin
      while ((words_seen - base_words) < 100 && t < 5000) begin @(negedge clk); #2; t++; end
      check({tag, "_reach_bin100"}, (t < 5000), 1);
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_rd_valid"}, rd_valid, 0);
      check({tag, "_rst_busy"}, busy, 0);
      check({tag, "_rst_rd_bin"}, rd_bin, 0);
      check({tag, "_rst_rd_count"}, rd_count, 0);
      check({tag, "_rst_rd_last"}, rd_last, 0);
      check({tag, "_rst_discard"}, discard_cnt, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      while (done_cnt == base_done && t < 5000) begin @(posedge clk); #1; t++; end
      check({tag, "_done_in_time"}, (t < 5000), 1);
      check({tag, "_discard_cnt"}, discard_cnt, disc);
      check({tag, "_words_left"}, exp_q.size(), 0);
    end
    $display("run %s: %0d events, acq_cycles=%0d, words=%0d, discards expected %0d",
             tag, ev_q.size(), acq_len, words_seen - base_words, disc);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      rd_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_chk   = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (stall_chk) begin
        check("stall_valid", rd_valid, 1);
        check("stall_bin", rd_bin, held_bin);
        check("stall_count", rd_count, held_cnt);
      end
      if (expect_done) begin
        check("acq_done_pulse", acq_done, 1);
        check("busy_after_dump", busy, 0);
      end else if (acq_done) begin
        check("acq_done_spurious", acq_done, 0);
      end
      if (acq_done) done_cnt++;
      expect_done = 1'b0;
      if (rd_valid && rd_ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_word: got bin %0d count %0d, required no word", rd_bin, rd_count);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("rd_bin", rd_bin, w.bin);
          check($sformatf("rd_count[%0d]", w.bin), rd_count, w.cnt);
          check("rd_last", rd_last, w.last);
          expect_done = w.last;
        end
      end
      stall_chk = rd_valid && !rd_ready;
      held_bin  = rd_bin;
      held_cnt  = rd_count;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got no completion, required finish within 3 ms");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_acq_done", acq_done, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_bin", rd_bin, 0);
    check("reset_rd_count", rd_count, 0);
    check("reset_rd_last", rd_last, 0);
    check("reset_discard", discard_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_evt(2'b01, 2'b01, 7'd9, 2, 2);
    check("idle_evt_discard", discard_cnt, 0);
    check("idle_busy", busy, 0);

    ev_q.delete();
    repeat (5) add_evt(2'b10, 2'b01, 7'd10, 2, 2, 1'b0);
    do_run("t1_pos", -1, 100, 1'b1, 1'b0, 1'b0);

    ev_q.delete();
    repeat (3) add_evt(2'b01, 2'b10, 7'd20, 2, 2, 1'b0);
    repeat (2) add_evt(2'b00, 2'b11, 7'($urandom), 2, 2, 1'b0);
    do_run("t2_neg_coinc", -1, 70, 1'b0, 1'b0, 1'b0);

    ev_q.delete();
    add_evt(2'b10, 2'b01, 7'd7, 6, 2, 1'b0);
    add_evt(2'b01, 2'b10, 7'd5, 3, 1, 1'b0);
    do_run("t3_level_hold", -1, 50, 1'b0, 1'b0, 1'b0);

    ev_q.delete();
    repeat (8)  add_evt(2'b10, 2'b01, 7'd2, 1, 1, 1'b0);
    repeat (20) add_evt(2'b01, 2'b10, 7'd12, 1, 1, 1'b0);
    add_evt(2'b01, 2'b10, 7'd127, 2, 2, 1'b0);
    add_evt(2'b10, 2'b01, 7'd127, 2, 2, 1'b0);
    add_evt(2'b10, 2'b01, 7'd0, 2, 2, 1'b0);
    do_run("t4_fwd_sat", -1, 100, 1'b0, 1'b0, 1'b0);

    ev_q.delete();
    add_evt(2'b10, 2'b10, 7'd5, 2, 2, 1'b0);
    add_evt(2'b11, 2'b01, 7'd5, 2, 2, 1'b0);
    do_run("t5_discard", -1, 100, 1'b0, 1'b0, 1'b0);

    ev_q.delete();
    gen_random(60);
    do_run("t6_random", -1, 30, 1'b1, 1'b1, 1'b0);

    ev_q.delete();
    gen_random(60);
    do_run("t7_reset_dump", -1, 30, 1'b0, 1'b0, 1'b1);
    check("post_reset_busy", busy, 0);

    ev_q.delete();
    do_run("t8_empty_acq", 0, 80, 1'b0, 1'b0, 1'b0);

    ev_q.delete();
    add_evt(2'b10, 2'b01, 7'd33, 1, 4, 1'b0);
    add_evt(2'b10, 2'b01, 7'd33, 2, 2, 1'b1);
    do_run("t9_window_edge", 7, 100, 1'b0, 1'b0, 1'b0);

    ev_q.delete();
    gen_random(40);
    do_run("t10_random", -1, 60, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
